led_bar_meter6: RTL



---
 rtl/led_meter_pkg.sv | 29 ++
 rtl/led_pwm_gen.sv | 25 ++
 rtl/led_bar_meter6.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/led_meter_pkg.sv
// Shared constants, peak FSM state type and the level-to-bar mapping for the
// LED bar meter.
package led_meter_pkg;

    localparam int LED_N = 6;
    localparam int CNT_W = 24;

    // Bar thresholds, index 0 = lowest LED: {4,12,22,32,44,56}.
    localparam logic [LED_N-1:0][5:0] THRESH = {6'd56, 6'd44, 6'd32, 6'd22, 6'd12, 6'd4};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        DECAY = 2'd2
    } peak_state_t;

    // Number of thresholds the level reaches, 0..6.
    function automatic logic [2:0] level_to_bar(input logic [5:0] level);
        logic [2:0] n;
        n = 3'd0;
        for (int k = 0; k < LED_N; k++) begin
            if (level >= THRESH[k]) begin
                n = n + 3'd1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/led_pwm_gen.sv
// Free-running PWM counter and duty compare for the bar LEDs.
// brightness_i is compared live; all-ones forces the output permanently on.
module led_pwm_gen #(
    parameter int PWM_BITS = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [PWM_BITS-1:0] brightness_i,
    output logic                pwm_on_o
);

    logic [PWM_BITS-1:0] r_cnt;

    // Counter increments every clock and wraps naturally.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + PWM_BITS'(1);
        end
    end

    assign pwm_on_o = (&brightness_i) || (r_cnt < brightness_i);

endmodule

// File: rtl/led_bar_meter6.sv
// 6-LED bar graph meter for the 6-bit activity envelope level, with an
// optional peak-hold dot that holds and then decays one LED per step.
// Optional feature macro: LED_BAR_PEAK_HOLD_EN (peak FSM, counters, peak dot).
// Without it the peak logic is absent and peak_idx_o is tied to zero.
//
// Input handshake: level_valid_i is a single-cycle strobe with no back-pressure;
// level6_i is sampled on every clock edge where level_valid_i is high and
// ignored otherwise. The bar is held between strobes.
module led_bar_meter6
    import led_meter_pkg::*;
#(
    parameter logic [23:0] HOLD_CYCLES  = 24'd12_000_000,
    parameter logic [23:0] DECAY_CYCLES = 24'd3_000_000,
    parameter int          PWM_BITS     = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                level_valid_i,
    input  logic [5:0]          level6_i,
    input  logic [PWM_BITS-1:0] brightness_i,
    output logic [5:0]          led_o,
    output logic [2:0]          peak_idx_o
);

    logic [2:0]       w_new_bar;
    logic [2:0]       r_bar;
    logic             w_pwm_on;
    logic [LED_N-1:0] w_bar_mask;
    logic [LED_N-1:0] w_peak_mask;
    logic [LED_N-1:0] r_led;

    assign w_new_bar = level_to_bar(level6_i);

    led_pwm_gen #(
        .PWM_BITS(PWM_BITS)
    ) u_pwm (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .brightness_i(brightness_i),
        .pwm_on_o    (w_pwm_on)
    );

    // Hold zero-length hold/decay periods out: the reload value would underflow.
    always_ff @(posedge clk_i) begin
        assert (HOLD_CYCLES != 24'd0 && DECAY_CYCLES != 24'd0);
    end

    // Bar height register, updated only on a level strobe.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_bar <= 3'd0;
        end else if (level_valid_i) begin
            r_bar <= w_new_bar;
        end
    end

    // Dimmed bar mask: LED k is in the bar when k < bar height.
    always_comb begin
        w_bar_mask = '0;
        for (int k = 0; k < LED_N; k++) begin
            w_bar_mask[k] = (3'(k) < r_bar) && w_pwm_on;
        end
    end

`ifdef LED_BAR_PEAK_HOLD_EN
    peak_state_t      r_state;
    logic [2:0]       r_peak;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_peak_idx;
    logic             w_capture;

    // A new bar at or above the current peak restarts the hold; it wins over
    // any expiry or decrement happening in the same cycle.
    assign w_capture = level_valid_i && (w_new_bar != 3'd0) && (w_new_bar >= r_peak);

    // Peak FSM: capture -> HOLD -> DECAY (one LED per step) -> IDLE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_peak  <= 3'd0;
            r_cnt   <= '0;
        end else if (w_capture) begin
            r_state <= HOLD;
            r_peak  <= w_new_bar;
            r_cnt   <= HOLD_CYCLES - 24'd1;
        end else begin
            case (r_state)
                IDLE: begin
                    r_peak <= 3'd0;
                    r_cnt  <= '0;
                end
                HOLD: begin
                    if (r_cnt == '0) begin
                        r_state <= DECAY;
                        r_cnt   <= DECAY_CYCLES - 24'd1;
                    end else begin
                        r_cnt <= r_cnt - 24'd1;
                    end
                end
                DECAY: begin
                    if (r_cnt == '0) begin
                        if (r_peak <= 3'd1) begin
                            r_state <= IDLE;
                            r_peak  <= 3'd0;
                            r_cnt   <= '0;
                        end else begin
                            r_peak <= r_peak - 3'd1;
                            r_cnt  <= DECAY_CYCLES - 24'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 24'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_peak  <= 3'd0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Peak dot: one full-brightness LED at position peak-1.
    always_comb begin
        w_peak_mask = '0;
        for (int k = 0; k < LED_N; k++) begin
            w_peak_mask[k] = (r_peak == 3'(k + 1));
        end
    end

    // Peak index output, registered alongside the LED drive.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_peak_idx <= 3'd0;
        end else begin
            r_peak_idx <= r_peak;
        end
    end

    assign peak_idx_o = r_peak_idx;
`else
    assign w_peak_mask = '0;
    assign peak_idx_o  = 3'd0;
`endif

    // Registered LED drive: dimmed bar plus peak dot.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_led <= '0;
        end else begin
            r_led <= w_bar_mask | w_peak_mask;
        end
    end

    assign led_o = r_led;

endmodule
